control_sequencer: RTL and testbench

- Sequencing stage directly upstream of the per-class instruction decoders, including the branch-condition decoder.
- Owns the instruction register, the 2-bit micro-step state register and the 5-bit status register; these drive the `instruction`, `state` and `status` inputs of every decoder.
- Accepts the selected decoder's 33-bit controlword, applies its `next_state` and `status_load` fields, and gates the controlword onto the datapath.
- Runs the fetch handshake with instruction memory.

---
 rtl/cpu_control_pkg.sv | 40 ++++
 rtl/control_sequencer_status.sv | 28 ++
 rtl/control_sequencer.sv | 120 ++++++++++++
 tb/tb_control_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_control_pkg.sv
// Shared controlword field map, status bit indices and sequencer encodings.
// Consumed by the control sequencer and by every per-class decoder.
package cpu_control_pkg;

   localparam int CW_WIDTH          = 33;
   localparam int CW_NEXT_STATE_LSB = 0;
   localparam int CW_NEXT_STATE_MSB = 1;
   localparam int CW_STATUS_LOAD    = 2;
   localparam int CW_PC_SEL         = 3;
   localparam int CW_PC_FUNC_LSB    = 4;
   localparam int CW_PC_FUNC_MSB    = 5;
   localparam int CW_PC_EN          = 6;
   localparam int CW_RAM_WRITE      = 7;
   localparam int CW_RAM_EN         = 8;
   localparam int CW_RF_WRITE       = 9;
   localparam int CW_DA_LSB         = 10;
   localparam int CW_SB_LSB         = 15;
   localparam int CW_SA_LSB         = 20;
   localparam int CW_RF_B_EN        = 25;
   localparam int CW_ALU_FUNC_LSB   = 26;
   localparam int CW_ALU_B_SEL      = 31;
   localparam int CW_ALU_EN         = 32;

   localparam int STATUS_Z = 4;
   localparam int STATUS_C = 3;
   localparam int STATUS_N = 2;
   localparam int STATUS_V = 1;

   typedef enum logic {
      SEQ_FETCH = 1'b0,
      SEQ_EXEC  = 1'b1
   } seq_state_e;

   function automatic logic [1:0] cw_next_state(
      input logic [CW_WIDTH-1:0] cw
   );
      return cw[CW_NEXT_STATE_MSB:CW_NEXT_STATE_LSB];
   endfunction

endpackage

// File: rtl/control_sequencer_status.sv
// Status register: {Z,C,N,V} flags with load enable; bit 0 reads as zero.
module status_register
   import cpu_control_pkg::*;
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic       load,
   input  logic [3:0] alu_status,
   output logic [4:0] status
);

   logic [3:0] flags_q;
   logic [3:0] flags_d;

   always_comb begin
      flags_d = flags_q;
      if (load) flags_d = alu_status;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) flags_q <= '0;
      else          flags_q <= flags_d;
   end

   assign status[STATUS_Z:STATUS_V] = flags_q;
   assign status[0]                 = 1'b0;

endmodule

// File: rtl/control_sequencer.sv
// FETCH/EXEC sequencer feeding the decoders and gating their controlword.
// Optional retire counter: CONTROL_SEQUENCER_RETIRE_COUNT_EN.
module control_sequencer
   import cpu_control_pkg::*;
#(
   parameter int unsigned MAX_EXEC_CYCLES = 4
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [31:0]         instruction_in,
   input  logic                instruction_valid,
   output logic                fetch_request,
   input  logic [CW_WIDTH-1:0] decoder_controlword,
   input  logic [3:0]          alu_status,
   output logic [31:0]         instruction,
   output logic [1:0]          state,
   output logic [4:0]          status,
   output logic [CW_WIDTH-1:0] controlword,
   output logic                fault
`ifdef CONTROL_SEQUENCER_RETIRE_COUNT_EN
   ,
   output logic [31:0]         retired_count
`endif
);

   localparam logic [4:0] MAX_CNT = 5'(MAX_EXEC_CYCLES);

   seq_state_e  fsm_q, fsm_d;
   logic [31:0] instr_q, instr_d;
   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        fault_q, fault_d;
   logic        status_ld;
   logic [1:0]  ns;

   assign ns = cw_next_state(decoder_controlword);

   always_comb begin
      fsm_d     = fsm_q;
      instr_d   = instr_q;
      state_d   = state_q;
      cnt_d     = cnt_q;
      fault_d   = fault_q;
      status_ld = 1'b0;
      unique case (fsm_q)
         SEQ_FETCH: begin
            if (instruction_valid) begin
               instr_d = instruction_in;
               state_d = 2'b00;
               cnt_d   = '0;
               fsm_d   = SEQ_EXEC;
            end
         end
         SEQ_EXEC: begin
            status_ld = decoder_controlword[CW_STATUS_LOAD];
            state_d   = ns;
            if (ns == 2'b00) begin
               fsm_d = SEQ_FETCH;
            end else if ({1'b0, cnt_q} + 5'd1 >= MAX_CNT) begin
               // Abort the runaway instruction; this cycle's
               // controlword has still been driven.
               fault_d = 1'b1;
               fsm_d   = SEQ_FETCH;
               state_d = 2'b00;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: fsm_d = SEQ_FETCH;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fsm_q   <= SEQ_FETCH;
         instr_q <= '0;
         state_q <= 2'b00;
         cnt_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         instr_q <= instr_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
      end
   end

   status_register u_status (
      .clock      (clock),
      .reset_n    (reset_n),
      .load       (status_ld),
      .alu_status (alu_status),
      .status     (status)
   );

`ifdef CONTROL_SEQUENCER_RETIRE_COUNT_EN
   logic [31:0] retired_q, retired_d;

   always_comb begin
      retired_d = retired_q;
      if (fsm_q == SEQ_EXEC && ns == 2'b00)
         retired_d = retired_q + 32'd1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) retired_q <= '0;
      else          retired_q <= retired_d;
   end

   assign retired_count = retired_q;
`endif

   assign fetch_request = (fsm_q == SEQ_FETCH);
   assign controlword   = (fsm_q == SEQ_EXEC) ? decoder_controlword : '0;
   assign instruction   = instr_q;
   assign state         = state_q;
   assign fault         = fault_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scenario-driven self-checking bench for control_sequencer.
// Expected instructions/controlwords go through scoreboard queues.
module tb_control_sequencer;

   logic        clock;
   logic        reset_n;
   logic [31:0] instruction_in;
   logic        instruction_valid;
   logic        fetch_request;
   logic [32:0] decoder_controlword;
   logic [3:0]  alu_status;
   logic [31:0] instruction;
   logic [1:0]  state;
   logic [4:0]  status;
   logic [32:0] controlword;
   logic        fault;
`ifdef CONTROL_SEQUENCER_RETIRE_COUNT_EN
   logic [31:0] retired_count;
`endif

   int n_cmp;
   int n_err;

   logic [31:0] instr_sb[$];
   logic [32:0] cw_sb[$];
   logic [4:0]  status_model;

   control_sequencer #(.MAX_EXEC_CYCLES(4)) dut (
      .clock               (clock),
      .reset_n             (reset_n),
      .instruction_in      (instruction_in),
      .instruction_valid   (instruction_valid),
      .fetch_request       (fetch_request),
      .decoder_controlword (decoder_controlword),
      .alu_status          (alu_status),
      .instruction         (instruction),
      .state               (state),
      .status              (status),
      .controlword         (controlword),
      .fault               (fault)
`ifdef CONTROL_SEQUENCER_RETIRE_COUNT_EN
      ,
      .retired_count       (retired_count)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Stimulus only: present a word for one edge, then drop valid.
   task automatic do_fetch(input logic [31:0] w);
      instruction_in    = w;
      instruction_valid = 1'b1;
      instr_sb.push_back(w);
      step();
      instruction_valid = 1'b0;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      status_model = 5'b0;
      #2;
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      logic [32:0] cw0;
      cw0 = '0;
      n_cmp++;
      if (state !== 2'b00) begin
         n_err++;
         $display("FAIL reset_state: got %b expected 00", state);
      end
      n_cmp++;
      if (status !== 5'b0) begin
         n_err++;
         $display("FAIL reset_status: got %b expected 00000", status);
      end
      n_cmp++;
      if (controlword !== cw0) begin
         n_err++;
         $display("FAIL reset_cw: got %h expected 0", controlword);
      end
      n_cmp++;
      if (fetch_request !== 1'b1 || fault !== 1'b0) begin
         n_err++;
         $display("FAIL reset_flags: got fr=%b fault=%b expected 1/0",
                  fetch_request, fault);
      end
      n_cmp++;
      if (instruction !== 32'h0) begin
         n_err++;
         $display("FAIL reset_instr: got %h expected 0", instruction);
      end
   endtask

   task automatic test_fetch_stall();
      logic [31:0] exp_i;
      decoder_controlword = 33'h1_FFFF_FFFF;
      instruction_valid   = 1'b0;
      instruction_in      = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++;
         if (controlword !== 33'h0 || fetch_request !== 1'b1) begin
            n_err++;
            $display("FAIL stall_cw%0d: got cw=%h fr=%b expected 0/1",
                     i, controlword, fetch_request);
         end
         n_cmp++;
         if (instruction !== 32'h0) begin
            n_err++;
            $display("FAIL stall_instr%0d: got %h expected 0",
                     i, instruction);
         end
      end
      do_fetch(32'h5400_0041);
      exp_i = instr_sb.pop_front();
      n_cmp++;
      if (instruction !== exp_i || fetch_request !== 1'b0) begin
         n_err++;
         $display("FAIL stall_load: got %h fr=%b expected %h fr=0",
                  instruction, fetch_request, exp_i);
      end
      decoder_controlword = 33'h0_0000_0200;
      step();
   endtask

   task automatic test_branch();
      logic [32:0] bcw;
      logic [32:0] exp_cw;
      bcw = '0;
      bcw[6]   = 1'b1;
      bcw[5:4] = 2'b11;
      bcw[3]   = 1'b1;
      do_fetch(32'hC000_0010);
      void'(instr_sb.pop_front());
      decoder_controlword = bcw;
      alu_status = 4'b1111;
      cw_sb.push_back(bcw);
      #1;
      exp_cw = cw_sb.pop_front();
      n_cmp++;
      if (controlword !== exp_cw) begin
         n_err++;
         $display("FAIL branch_cw: got %h expected %h", controlword, exp_cw);
      end
      step();
      n_cmp++;
      if (controlword !== 33'h0 || fetch_request !== 1'b1) begin
         n_err++;
         $display("FAIL branch_ret: got cw=%h fr=%b expected 0/1",
                  controlword, fetch_request);
      end
      n_cmp++;
      if (status !== status_model) begin
         n_err++;
         $display("FAIL branch_status: got %b expected %b",
                  status, status_model);
      end
   endtask

   task automatic test_multicycle();
      logic [32:0] c0, c1, exp_cw;
      c0 = 33'h1_0000_0601;
      c1 = 33'h0_0210_0004;
      do_fetch(32'h1234_5678);
      void'(instr_sb.pop_front());
      decoder_controlword = c0;
      alu_status = 4'b0110;
      cw_sb.push_back(c0);
      #1;
      exp_cw = cw_sb.pop_front();
      n_cmp++;
      if (state !== 2'b00 || controlword !== exp_cw) begin
         n_err++;
         $display("FAIL mc_step0: got st=%b cw=%h expected 00/%h",
                  state, controlword, exp_cw);
      end
      step();
      decoder_controlword = c1;
      alu_status = 4'b1001;
      cw_sb.push_back(c1);
      #1;
      exp_cw = cw_sb.pop_front();
      n_cmp++;
      if (state !== 2'b01 || controlword !== exp_cw) begin
         n_err++;
         $display("FAIL mc_step1: got st=%b cw=%h expected 01/%h",
                  state, controlword, exp_cw);
      end
      step();
      status_model = 5'b10010;
      n_cmp++;
      if (status !== status_model || fetch_request !== 1'b1) begin
         n_err++;
         $display("FAIL mc_retire: got st=%b fr=%b expected %b/1",
                  status, fetch_request, status_model);
      end
   endtask

   task automatic test_watchdog();
      do_fetch(32'hAAAA_0001);
      void'(instr_sb.pop_front());
      decoder_controlword = 33'h0_0000_0001;
      alu_status = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (fault !== 1'b0 || fetch_request !== 1'b0) begin
            n_err++;
            $display("FAIL wd_pre%0d: got fault=%b fr=%b expected 0/0",
                     i, fault, fetch_request);
         end
         step();
      end
      n_cmp++;
      if (fault !== 1'b1 || fetch_request !== 1'b1 || state !== 2'b00) begin
         n_err++;
         $display("FAIL wd_fire: got f=%b fr=%b st=%b expected 1/1/00",
                  fault, fetch_request, state);
      end
      n_cmp++;
      if (status !== status_model) begin
         n_err++;
         $display("FAIL wd_status: got %b expected %b", status, status_model);
      end
      do_fetch(32'hBBBB_0002);
      void'(instr_sb.pop_front());
      decoder_controlword = 33'h0;
      step();
      n_cmp++;
      if (fault !== 1'b1) begin
         n_err++;
         $display("FAIL wd_sticky: got %b expected 1", fault);
      end
      apply_reset();
      n_cmp++;
      if (fault !== 1'b0) begin
         n_err++;
         $display("FAIL wd_clear: got %b expected 0", fault);
      end
   endtask

   task automatic test_reset_mid_exec();
      do_fetch(32'h0F0F_0F0F);
      void'(instr_sb.pop_front());
      decoder_controlword = 33'h0_0000_0005;
      alu_status = 4'b1010;
      step();
      n_cmp++;
      if (state !== 2'b01 || status !== 5'b10100) begin
         n_err++;
         $display("FAIL rme_setup: got st=%b status=%b expected 01/10100",
                  state, status);
      end
      decoder_controlword = 33'h1_2345_6781;
      #2;
      reset_n = 1'b0;
      status_model = 5'b0;
      #1;
      n_cmp++;
      if (state !== 2'b00 || status !== 5'b0 || controlword !== 33'h0
          || fetch_request !== 1'b1) begin
         n_err++;
         $display("FAIL rme_async: got st=%b sr=%b cw=%h fr=%b",
                  state, status, controlword, fetch_request);
      end
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_i;
      decoder_controlword = 33'h0_0000_0040;
      instruction_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         instruction_in = $urandom;
         instr_sb.push_back(instruction_in);
         step();
         exp_i = instr_sb.pop_front();
         n_cmp++;
         if (instruction !== exp_i || fetch_request !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_load%0d: got %h fr=%b expected %h fr=0",
                     i, instruction, fetch_request, exp_i);
         end
         instruction_in = ~exp_i;
         step();
         n_cmp++;
         if (fetch_request !== 1'b1 || instruction !== exp_i) begin
            n_err++;
            $display("FAIL b2b_ret%0d: got fr=%b %h expected 1 %h",
                     i, fetch_request, instruction, exp_i);
         end
      end
      instruction_valid = 1'b0;
   endtask

`ifdef CONTROL_SEQUENCER_RETIRE_COUNT_EN
   task automatic test_retire_count();
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         do_fetch(32'h100 + i);
         void'(instr_sb.pop_front());
         decoder_controlword = 33'h0;
         step();
      end
      do_fetch(32'h200);
      void'(instr_sb.pop_front());
      decoder_controlword = 33'h0_0000_0002;
      for (int i = 0; i < 4; i++) step();
      n_cmp++;
      if (retired_count !== 32'd3 || fault !== 1'b1) begin
         n_err++;
         $display("FAIL rc_count: got %0d fault=%b expected 3/1",
                  retired_count, fault);
      end
      dut.retired_q = 32'hFFFF_FFFF;
      for (int i = 0; i < 2; i++) begin
         do_fetch(32'h300 + i);
         void'(instr_sb.pop_front());
         decoder_controlword = 33'h0;
         step();
         n_cmp++;
         if (retired_count !== 32'(i)) begin
            n_err++;
            $display("FAIL rc_wrap%0d: got %h expected %h",
                     i, retired_count, 32'(i));
         end
      end
   endtask
`endif

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset_n = 1'b0;
      instruction_in = '0;
      instruction_valid = 1'b0;
      decoder_controlword = 33'h1_5555_5555;
      alu_status = 4'b1111;
      status_model = 5'b0;
      #1;
      test_reset();
      @(negedge clock);
      reset_n = 1'b1;
      test_fetch_stall();
      test_branch();
      test_multicycle();
      test_watchdog();
      test_reset_mid_exec();
      test_back_to_back();
`ifdef CONTROL_SEQUENCER_RETIRE_COUNT_EN
      test_retire_count();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
